// File: rtl/reorder_buffer.sv
// Two-wide in-order retirement buffer: dispatch allocates tags at the tail, EX completes
// entries by tag in any order, and up to two completed head entries retire each cycle.
module reorder_buffer #(
  parameter int DEPTH_LOG = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 alloc_req,
  input  logic [1:0][4:0]            alloc_rd,
  output logic                       alloc_ready,
  output logic [1:0][DEPTH_LOG-1:0]  alloc_tag,
  input  logic [1:0]                 cmp_valid,
  input  logic [1:0][DEPTH_LOG-1:0]  cmp_tag,
  input  logic [1:0][31:0]           cmp_result,
  input  logic [1:0]                 cmp_taken,
  input  logic [1:0][31:0]           cmp_target,
  output logic [1:0]                 commit_valid,
  output logic [1:0][4:0]            commit_rd,
  output logic [1:0][31:0]           commit_data,
  output logic                       flush,
  output logic [31:0]                flush_pc
);

  localparam int DEPTH = 1 << DEPTH_LOG;
  typedef logic [DEPTH_LOG-1:0] ptr_t;
  typedef logic [DEPTH_LOG:0]   cnt_t;

  // Handshake: alloc_req is consumed at the rising edge only while alloc_ready is high;
  // a dropped request carries no state and dispatch simply re-presents it.

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [DEPTH-1:0] done_q, done_d;
  logic [DEPTH-1:0] taken_q, taken_d;
  logic [4:0]       rd_q     [DEPTH];
  logic [4:0]       rd_d     [DEPTH];
  logic [31:0]      data_q   [DEPTH];
  logic [31:0]      data_d   [DEPTH];
  logic [31:0]      target_q [DEPTH];
  logic [31:0]      target_d [DEPTH];

  ptr_t head_q, head_d;
  ptr_t tail_q, tail_d;
  cnt_t count_q, count_d;

  ptr_t       h1;
  ptr_t       ret_idx [2];
  logic       flush0, flush1;
  logic [1:0] n_ret;
  logic       alloc_fire0, alloc_fire1;
  logic [1:0] n_alloc;

  // Retirement looks only at registered state, so a completion needs one edge to be seen.
  always_comb begin
    h1             = head_q + ptr_t'(1);
    ret_idx[0]     = head_q;
    ret_idx[1]     = h1;
    commit_valid   = '0;
    commit_valid[0] = busy_q[head_q] & done_q[head_q];
    commit_valid[1] = commit_valid[0] & busy_q[h1] & done_q[h1] & ~taken_q[head_q];
    commit_rd[0]   = rd_q[head_q];
    commit_rd[1]   = rd_q[h1];
    commit_data[0] = data_q[head_q];
    commit_data[1] = data_q[h1];
    flush0         = commit_valid[0] & taken_q[head_q];
    flush1         = commit_valid[1] & taken_q[h1];
    flush          = flush0 | flush1;
    if (flush0) begin
      flush_pc = target_q[head_q];
    end else if (flush1) begin
      flush_pc = target_q[h1];
    end else begin
      flush_pc = '0;
    end
    n_ret = {1'b0, commit_valid[0]} + {1'b0, commit_valid[1]};
  end

  always_comb begin
    alloc_ready  = (count_q <= cnt_t'(DEPTH - 2)) && !flush;
    alloc_tag[0] = tail_q;
    alloc_tag[1] = tail_q + ptr_t'(1);
    alloc_fire0  = alloc_ready & alloc_req[0];
    alloc_fire1  = alloc_fire0 & alloc_req[1];
    n_alloc      = {1'b0, alloc_fire0} + {1'b0, alloc_fire1};
  end

  always_comb begin
    busy_d   = busy_q;
    done_d   = done_q;
    taken_d  = taken_q;
    rd_d     = rd_q;
    data_d   = data_q;
    target_d = target_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    if (flush) begin
      // Everything younger than the branch dies; same-cycle alloc/completion are dropped.
      busy_d  = '0;
      done_d  = '0;
      head_d  = head_q + ptr_t'(n_ret);
      tail_d  = head_q + ptr_t'(n_ret);
      count_d = '0;
    end else begin
      // Slot 1 is applied last so it wins a same-tag double completion.
      for (int s = 0; s < 2; s++) begin
        if (cmp_valid[s] && busy_q[cmp_tag[s]]) begin
          done_d[cmp_tag[s]]   = 1'b1;
          data_d[cmp_tag[s]]   = cmp_result[s];
          taken_d[cmp_tag[s]]  = cmp_taken[s];
          target_d[cmp_tag[s]] = cmp_target[s];
        end
      end
      for (int s = 0; s < 2; s++) begin
        if (commit_valid[s]) begin
          busy_d[ret_idx[s]] = 1'b0;
          done_d[ret_idx[s]] = 1'b0;
        end
      end
      if (alloc_fire0) begin
        busy_d[alloc_tag[0]]  = 1'b1;
        done_d[alloc_tag[0]]  = 1'b0;
        taken_d[alloc_tag[0]] = 1'b0;
        rd_d[alloc_tag[0]]    = alloc_rd[0];
      end
      if (alloc_fire1) begin
        busy_d[alloc_tag[1]]  = 1'b1;
        done_d[alloc_tag[1]]  = 1'b0;
        taken_d[alloc_tag[1]] = 1'b0;
        rd_d[alloc_tag[1]]    = alloc_rd[1];
      end
      head_d  = head_q + ptr_t'(n_ret);
      tail_d  = tail_q + ptr_t'(n_alloc);
      count_d = count_q + cnt_t'(n_alloc) - cnt_t'(n_ret);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= '0;
      done_q  <= '0;
      taken_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      done_q  <= done_d;
      taken_q <= taken_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage is qualified by busy/done, so it needs no reset.
  always_ff @(posedge clk) begin
    rd_q     <= rd_d;
    data_q   <= data_d;
    target_q <= target_d;
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: stimulus pushes expected retirements into a queue and a
// negedge monitor pops and compares every commit the DUT presents.
module tb_reorder_buffer;

  localparam int W = 70;

  logic                 clk;
  logic                 rst_n;
  logic [1:0]           alloc_req;
  logic [1:0][4:0]      alloc_rd;
  logic                 alloc_ready;
  logic [1:0][3:0]      alloc_tag;
  logic [1:0]           cmp_valid;
  logic [1:0][3:0]      cmp_tag;
  logic [1:0][31:0]     cmp_result;
  logic [1:0]           cmp_taken;
  logic [1:0][31:0]     cmp_target;
  logic [1:0]           commit_valid;
  logic [1:0][4:0]      commit_rd;
  logic [1:0][31:0]     commit_data;
  logic                 flush;
  logic [31:0]          flush_pc;

  logic [W-1:0] exp_q[$];
  int total;
  int bad;
  logic [3:0] tb_tail;
  logic [3:0] prev_t;
  logic [3:0] t;

  reorder_buffer #(.DEPTH_LOG(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_req(alloc_req), .alloc_rd(alloc_rd),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .cmp_valid(cmp_valid), .cmp_tag(cmp_tag), .cmp_result(cmp_result),
    .cmp_taken(cmp_taken), .cmp_target(cmp_target),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_data(commit_data),
    .flush(flush), .flush_pc(flush_pc)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_req  = '0;
    alloc_rd   = '0;
    cmp_valid  = '0;
    cmp_tag    = '0;
    cmp_result = '0;
    cmp_taken  = '0;
    cmp_target = '0;
  endtask

  task automatic set_cmp(input int s, input logic [3:0] tag, input logic [31:0] res,
                         input logic tk, input logic [31:0] tgt);
    cmp_valid[s]  = 1'b1;
    cmp_tag[s]    = tag;
    cmp_result[s] = res;
    cmp_taken[s]  = tk;
    cmp_target[s] = tgt;
  endtask

  task automatic push_exp(input logic [4:0] rd, input logic [31:0] d,
                          input logic fl, input logic [31:0] pc);
    exp_q.push_back({rd, d, fl, pc});
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      logic [W-1:0] act;
      logic [W-1:0] exp;
      logic         last;
      if (commit_valid == 2'b10) begin
        total++; bad++;
        $display("FAIL commit_order: got commit_valid=10 expected slot 0 set");
      end
      if (flush && commit_valid == 2'b00) begin
        total++; bad++;
        $display("FAIL flush_no_commit: got flush=1 expected flush=0");
      end
      if (!flush && flush_pc != 32'h0) begin
        total++; bad++;
        $display("FAIL flush_pc_idle: got %0h expected 0", flush_pc);
      end
      for (int i = 0; i < 2; i++) begin
        if (commit_valid[i]) begin
          last = (i == 1) || !commit_valid[1];
          act  = {commit_rd[i], commit_data[i], flush && last,
                  (flush && last) ? flush_pc : 32'h0};
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL commit_extra: got rd=%0d data=%0h expected none", commit_rd[i],
                     commit_data[i]);
          end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
              bad++;
              $display("FAIL commit_slot%0d: got rd=%0d data=%0h fl=%0b pc=%0h expected rd=%0d data=%0h fl=%0b pc=%0h",
                       i, act[69:65], act[64:33], act[32], act[31:0],
                       exp[69:65], exp[64:33], exp[32], exp[31:0]);
            end
          end
        end
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    idle_inputs();
    #3;
    check("rst_ready", alloc_ready, 1);
    check("rst_tag0", alloc_tag[0], 0);
    check("rst_tag1", alloc_tag[1], 1);
    check("rst_cv", commit_valid, 0);
    check("rst_flush", flush, 0);
    check("rst_flush_pc", flush_pc, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // out-of-order completion, dual retirement
    alloc_req = 2'b11; alloc_rd[0] = 5'd5; alloc_rd[1] = 5'd6;
    check("t2_tag0", alloc_tag[0], 0);
    check("t2_tag1", alloc_tag[1], 1);
    tick();
    idle_inputs();
    set_cmp(0, 4'd1, 32'h22, 1'b0, 32'h0);
    tick();
    check("t2_wait_cv", commit_valid, 0);
    idle_inputs();
    set_cmp(0, 4'd0, 32'h11, 1'b0, 32'h0);
    push_exp(5'd5, 32'h11, 1'b0, 32'h0);
    push_exp(5'd6, 32'h22, 1'b0, 32'h0);
    tick();
    check("t2_dual_cv", commit_valid, 2'b11);
    idle_inputs();
    tick();
    check("t2_after_cv", commit_valid, 0);
    check("t2_tail", alloc_tag[0], 2);
    tb_tail = 4'd2;

    // fill to full, drop while full, then drain
    for (int k = 0; k < 8; k++) begin
      check("t3_ready", alloc_ready, 1);
      t = tb_tail + 4'(2 * k);
      alloc_req = 2'b11;
      alloc_rd[0] = 5'(t) + 5'd1;
      alloc_rd[1] = 5'(t + 4'd1) + 5'd1;
      tick();
    end
    check("t3_full_ready", alloc_ready, 0);
    tick();
    check("t3_drop_tail", alloc_tag[0], tb_tail);
    check("t3_drop_ready", alloc_ready, 0);
    idle_inputs();
    for (int k = 0; k < 8; k++) begin
      idle_inputs();
      t = tb_tail + 4'(2 * k);
      set_cmp(0, t, 32'h300 + 32'(t), 1'b0, 32'h0);
      set_cmp(1, t + 4'd1, 32'h300 + 32'(t + 4'd1), 1'b0, 32'h0);
      push_exp(5'(t) + 5'd1, 32'h300 + 32'(t), 1'b0, 32'h0);
      push_exp(5'(t + 4'd1) + 5'd1, 32'h300 + 32'(t + 4'd1), 1'b0, 32'h0);
      tick();
    end
    idle_inputs();
    repeat (3) tick();
    check("t3_drained_ready", alloc_ready, 1);
    check("t3_drained_cv", commit_valid, 0);

    // back-to-back stream across the tag wrap
    prev_t = tb_tail;
    for (int i = 0; i <= 20; i++) begin
      idle_inputs();
      if (i < 20) begin
        check("t4_ready", alloc_ready, 1);
        check("t4_tag0", alloc_tag[0], tb_tail);
        check("t4_tag1", alloc_tag[1], tb_tail + 4'd1);
        alloc_req = 2'b11;
        alloc_rd[0] = 5'(i + 10);
        alloc_rd[1] = 5'(i + 11);
      end
      if (i > 0) begin
        set_cmp(0, prev_t, 32'h4000 + 32'(2 * (i - 1)), 1'b0, 32'h0);
        set_cmp(1, prev_t + 4'd1, 32'h4001 + 32'(2 * (i - 1)), 1'b0, 32'h0);
        push_exp(5'(i + 9), 32'h4000 + 32'(2 * (i - 1)), 1'b0, 32'h0);
        push_exp(5'(i + 10), 32'h4001 + 32'(2 * (i - 1)), 1'b0, 32'h0);
      end
      prev_t = tb_tail;
      if (i < 20) tb_tail = tb_tail + 4'd2;
      tick();
    end
    idle_inputs();
    repeat (3) tick();
    check("t4_tail", alloc_tag[0], tb_tail);

    // asynchronous reset with five live entries, head ready to retire
    alloc_req = 2'b11;
    tick();
    alloc_req = 2'b11;
    tick();
    idle_inputs();
    alloc_req = 2'b01;
    set_cmp(0, tb_tail, 32'hdead, 1'b0, 32'h0);
    tick();
    idle_inputs();
    check("t1_pre_cv", commit_valid, 2'b01);
    #1 rst_n = 1'b0;
    #1;
    check("t1_cv", commit_valid, 0);
    check("t1_ready", alloc_ready, 1);
    check("t1_tag0", alloc_tag[0], 0);
    check("t1_tag1", alloc_tag[1], 1);
    tick();
    #2 rst_n = 1'b1;
    tick();
    check("t1_post_cv", commit_valid, 0);
    check("t1_post_ready", alloc_ready, 1);
    check("t1_post_tag0", alloc_tag[0], 0);

    // taken branch in slot 0 flushes the younger done entry
    alloc_req = 2'b11; alloc_rd[0] = 5'd7; alloc_rd[1] = 5'd8;
    tick();
    idle_inputs();
    set_cmp(0, 4'd0, 32'h1234, 1'b1, 32'h100);
    set_cmp(1, 4'd1, 32'h55, 1'b0, 32'h0);
    push_exp(5'd7, 32'h1234, 1'b1, 32'h100);
    tick();
    idle_inputs();
    check("t5_cv", commit_valid, 2'b01);
    check("t5_flush", flush, 1);
    check("t5_flush_pc", flush_pc, 32'h100);
    check("t5_ready", alloc_ready, 0);
    alloc_req = 2'b11;
    set_cmp(0, 4'd2, 32'h77, 1'b0, 32'h0);
    tick();
    idle_inputs();
    check("t5_post_cv", commit_valid, 0);
    check("t5_post_flush", flush, 0);
    check("t5_post_pc", flush_pc, 0);
    check("t5_post_ready", alloc_ready, 1);
    check("t5_post_tag0", alloc_tag[0], 1);
    check("t5_post_tag1", alloc_tag[1], 2);
    tick();
    check("t5_no_tag1", commit_valid, 0);

    // stale completion, slot-1-only request, same-tag double completion
    set_cmp(0, 4'd1, 32'h99, 1'b0, 32'h0);
    alloc_req = 2'b10;
    tick();
    idle_inputs();
    check("t6_slot1_only", alloc_tag[0], 1);
    check("t6_stale_cv", commit_valid, 0);
    alloc_req = 2'b01; alloc_rd[0] = 5'd9;
    tick();
    idle_inputs();
    check("t6_single_tag", alloc_tag[0], 2);
    check("t6_busy_cv", commit_valid, 0);
    set_cmp(0, 4'd1, 32'hA, 1'b0, 32'h0);
    set_cmp(1, 4'd1, 32'hB, 1'b0, 32'h0);
    push_exp(5'd9, 32'hB, 1'b0, 32'h0);
    tick();
    idle_inputs();
    check("t6_cv", commit_valid, 2'b01);
    check("t6_flush", flush, 0);
    tick();
    check("t6_after_cv", commit_valid, 0);

    repeat (3) tick();
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
